reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  - 32 x 64-bit LEGv8 general register file (X0..X30, X31 = XZR).
//  - Decode stage; feeds the execute-stage ALU.
//  - read_data1 drives the ALU data_a operand. read_data2 drives the ALU data_b operand through the ALUSrc mux.
//  - Writeback result returns on the write port.
//  - Includes a same-cycle write->read bypass.
//  - Optional busy-bit scoreboard raises a hazard stall.
// PARAMETERS
//  - DATA_WIDTH  64  register/operand width; must match the ALU width.
//  - ADDR_WIDTH  5   register index width.
//  - NUM_REGS    32  register count; index NUM_REGS-1 is XZR.
// PORTS
//  - clk         in   1   clock; all state updates on the rising edge.
//  - rst         in   1   reset, asynchronous, active-high.
//  - read_reg1   in   5   read port 1 index (Rn).
//  - read_reg2   in   5   read port 2 index (Rm/Rt).
//  - read_data1  out  64  port 1 data (ALU data_a).
//  - read_data2  out  64  port 2 data (ALU data_b via mux).
//  - reg_write   in   1   write enable from writeback.
//  - write_reg   in   5   write index (Rd).
//  - write_data  in   64  write data (ALU result or memory load).
//  - issue_valid in   1   an instruction writing issue_dest issues this cycle.
//  - issue_dest  in   5   destination index of the issuing instruction.
//  - STALL       out  1   read hazard on a pending destination; hold decode.
// BEHAVIOUR
//  - Reads are combinational, with zero cycles of latency from index to data.
//  - XZR: any read of index 31 returns 64'h0. Writes to 31 are discarded and never bypassed.
//  - Write: at posedge clk, if reg_write && write_reg!=31, the register becomes write_data.
//  - Bypass: if reg_write && write_reg==read_regN && write_reg!=31, read_dataN=write_data in the same cycle, before the edge.
//  - Bypass applies to both ports independently. Both ports may read the same index.
//  - Reset: rst=1 clears X0..X30 to 0 immediately, without waiting for clk.
//    - While rst=1, writes are blocked and bypass is suppressed, so read_data1/2 = 0 and STALL = 0.
//  - Reset mid-operation: a write coinciding with the rst assertion is lost.
//    - Outputs go to 0 within the same cycle.
//    - The first write is accepted at the first posedge after rst deasserts.
//  - Widths: no truncation or extension; all data is DATA_WIDTH bits unsigned storage.
// CONFIGURATION
//  - Macro REGFILE_SCOREBOARD_EN enables the busy-bit scoreboard.
//  - Defined:
//    - busy[30:0] is cleared on reset.
//    - At posedge, issue_valid && !STALL && issue_dest!=31 sets busy[issue_dest].
//    - At posedge, reg_write && write_reg!=31 clears busy[write_reg].
//    - If the same index is both set and cleared in one cycle, set wins (new producer).
//    - STALL = (busy[read_reg1] && !byp1) || (busy[read_reg2] && !byp2).
//      - bypN = reg_write && write_reg==read_regN.
//      - Index 31 is never busy.
//    - issue_valid is ignored while STALL=1.
//  - Undefined: no busy state; STALL tied 0; issue_valid/issue_dest ignored. Ports remain present.
// TESTING
//  - Reset: pulse rst mid-cycle, sweep read_reg1/2 over 0..31 -> all read_data = 64'h0, STALL=0.
//  - Write X5=64'hDEADBEEFCAFEBABE; next cycle read_reg1=5, read_reg2=31 -> read_data1=64'hDEADBEEFCAFEBABE, read_data2=0.
//  - Write X31=64'hFFFFFFFFFFFFFFFF; next cycle read_reg1=31 -> 64'h0.
//  - Bypass: reg_write=1, write_reg=7, write_data=64'h1122334455667788, read_reg2=7 in the same cycle -> read_data2=64'h1122334455667788 before the edge.
//  - Async reset: write X3=64'd100 and read X3 -> 100. Then assert rst between edges -> read_data1=0 immediately; still 0 after release.
//  - Scoreboard (macro on): issue_valid=1, issue_dest=9.
//    - Next cycle read_reg1=9 -> STALL=1.
//    - Then reg_write X9=64'd42 -> STALL=0 that cycle, read_data1=42. Macro off -> STALL stays 0 throughout.

Source files
------------

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file
//  Description : 32 x 64-bit LEGv8 general register file (X0..X30, X31 = XZR)
//                for the decode stage. It has two combinational read ports,
//                one writeback port and a same-cycle write->read bypass.
//                Define REGFILE_SCOREBOARD_EN to build the optional busy-bit
//                scoreboard, which drives STALL on a read of a pending
//                destination. When the macro is undefined, STALL is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic                  reg_write,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  output logic                  STALL
);

  // The highest index is the hard-wired zero register (XZR).
  localparam logic [ADDR_WIDTH-1:0] c_xzr = ADDR_WIDTH'(NUM_REGS - 1);

  // Only X0..X30 have storage. XZR is synthesised as a constant.
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1];

  // A write is effective only to a real register while reset is released.
  // The same qualifier gates the bypass, so reset also hides in-flight data.
  logic w_wr_en;
  assign w_wr_en = reg_write && (write_reg != c_xzr) && !rst;

  // Explicit mux over the stored registers. It avoids an out-of-range array
  // index when the address is XZR, which then falls through to zero.
  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] idx);
    f_read = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (idx == ADDR_WIDTH'(i)) f_read = r_regs[i];
    end
  endfunction

  // Register storage: asynchronous clear, single write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[write_reg] <= write_data;
    end
  end

  // Read port 1: zero in reset or for XZR, else bypassed or stored data.
  always_comb begin
    read_data1 = '0;
    if (!rst && (read_reg1 != c_xzr)) begin
      if (w_wr_en && (write_reg == read_reg1)) read_data1 = write_data;
      else                                     read_data1 = f_read(read_reg1);
    end
  end

  // Read port 2: same selection as port 1, with an independent bypass compare.
  always_comb begin
    read_data2 = '0;
    if (!rst && (read_reg2 != c_xzr)) begin
      if (w_wr_en && (write_reg == read_reg2)) read_data2 = write_data;
      else                                     read_data2 = f_read(read_reg2);
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  // One busy bit per real register. XZR is padded in as never busy.
  logic [NUM_REGS-2:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_ext;
  logic                w_byp1;
  logic                w_byp2;
  logic                w_issue;

  assign w_busy_ext = {1'b0, r_busy};

  // The writeback completing this cycle satisfies the reader through the bypass.
  assign w_byp1 = reg_write && (write_reg == read_reg1);
  assign w_byp2 = reg_write && (write_reg == read_reg2);

  assign STALL = !rst && ((w_busy_ext[read_reg1] && !w_byp1) ||
                          (w_busy_ext[read_reg2] && !w_byp2));

  // A stalled decode does not issue. Issues that target XZR never reserve a register.
  assign w_issue = issue_valid && !STALL && (issue_dest != c_xzr);

  // Busy-bit update: a new producer's set takes priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (w_issue && (issue_dest == ADDR_WIDTH'(i)))        r_busy[i] <= 1'b1;
        else if (w_wr_en && (write_reg == ADDR_WIDTH'(i)))    r_busy[i] <= 1'b0;
      end
    end
  end
`else
  // No hazard tracking. The issue inputs stay on the port list but are unused.
  logic w_unused_issue;
  assign w_unused_issue = ^{issue_valid, issue_dest};
  assign STALL          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file
//  Description : Directed, self-checking bench for reg_file. Each step queues
//                the expected read_data1/read_data2/STALL values, and the
//                queue is drained against the DUT outputs once they settle.
//                Expected STALL follows REGFILE_SCOREBOARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;

`ifdef REGFILE_SCOREBOARD_EN
  localparam logic c_sb = 1'b1;
`else
  localparam logic c_sb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  read_reg1 = '0;
  logic [4:0]  read_reg2 = '0;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic        reg_write = 1'b0;
  logic [4:0]  write_reg = '0;
  logic [63:0] write_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_dest = '0;
  logic        STALL;

  reg_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .issue_valid(issue_valid),
    .issue_dest (issue_dest),
    .STALL      (STALL)
  );

  // A 100-time-unit period leaves room for a full 32-entry sweep in one phase.
  always #50 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic push_exp(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        0:       obs = read_data1;
        1:       obs = read_data2;
        default: obs = {63'd0, STALL};
      endcase
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [63:0] e1, input logic [63:0] e2, input logic es);
    read_reg1 = r1;
    read_reg2 = r2;
    push_exp({tag, ".rd1"}, 0, e1);
    push_exp({tag, ".rd2"}, 1, e2);
    push_exp({tag, ".stall"}, 2, {63'd0, es});
    #1;
    drain();
  endtask

  localparam logic [63:0] c_x5 = 64'hDEADBEEFCAFEBABE;
  localparam logic [63:0] c_x7 = 64'h1122334455667788;

  initial begin
    // Reset pulsed between edges. A write is presented but must be blocked.
    #20 rst = 1'b1;
    check("rst_early", 5'd0, 5'd31, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 64'hA5A5A5A5A5A5A5A5;
    for (int i = 0; i < 32; i++)
      check($sformatf("rst_sweep%0d", i), i[4:0], 5'(31 - i), 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    check("rst_hold_wr", 5'd5, 5'd5, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    reg_write = 1'b0;
    check("rst_release", 5'd5, 5'd0, 64'd0, 64'd0, 1'b0);

    // Basic write then read, with XZR on port 2.
    reg_write = 1'b1; write_reg = 5'd5; write_data = c_x5;
    @(negedge clk);
    reg_write = 1'b0;
    check("x5_rd", 5'd5, 5'd31, c_x5, 64'd0, 1'b0);

    // XZR writes are discarded and never bypassed.
    reg_write = 1'b1; write_reg = 5'd31; write_data = '1;
    check("xzr_wr_same", 5'd31, 5'd31, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    reg_write = 1'b0;
    check("xzr_rd", 5'd31, 5'd5, 64'd0, c_x5, 1'b0);

    // Same-cycle bypass on port 2, then on both ports reading one index.
    reg_write = 1'b1; write_reg = 5'd7; write_data = c_x7;
    check("byp_p2", 5'd5, 5'd7, c_x5, c_x7, 1'b0);
    check("byp_both", 5'd7, 5'd7, c_x7, c_x7, 1'b0);
    @(negedge clk);
    reg_write = 1'b0;
    check("x7_stored", 5'd7, 5'd5, c_x7, c_x5, 1'b0);
    check("same_idx", 5'd5, 5'd5, c_x5, c_x5, 1'b0);

    // Asynchronous reset between edges while a write is pending.
    reg_write = 1'b1; write_reg = 5'd3; write_data = 64'd100;
    @(negedge clk);
    reg_write = 1'b0;
    check("x3_rd", 5'd3, 5'd7, 64'd100, c_x7, 1'b0);
    #10;
    rst = 1'b1; reg_write = 1'b1; write_reg = 5'd3; write_data = 64'd55;
    check("async_rst", 5'd3, 5'd7, 64'd0, 64'd0, 1'b0);
    @(posedge clk); #1;
    check("rst_at_edge", 5'd3, 5'd3, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0; reg_write = 1'b0;
    check("after_release", 5'd3, 5'd7, 64'd0, 64'd0, 1'b0);
    reg_write = 1'b1; write_reg = 5'd3; write_data = 64'd77;
    @(negedge clk);
    reg_write = 1'b0;
    check("first_wr", 5'd3, 5'd5, 64'd77, 64'd0, 1'b0);

    // Scoreboard: issue X9, then try to issue X10 while stalled.
    issue_valid = 1'b1; issue_dest = 5'd9;
    check("issue9", 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    issue_dest = 5'd10;
    check("stall9", 5'd9, 5'd0, 64'd0, 64'd0, c_sb);
    @(negedge clk);
    issue_valid = 1'b0;
    reg_write = 1'b1; write_reg = 5'd9; write_data = 64'd42;
    check("wb9_byp", 5'd9, 5'd10, 64'd42, 64'd0, 1'b0);
    @(negedge clk);
    reg_write = 1'b0;
    check("wb9_done", 5'd9, 5'd10, 64'd42, 64'd0, 1'b0);

    // Set wins over clear on the same index in one cycle.
    issue_valid = 1'b1; issue_dest = 5'd12;
    reg_write = 1'b1; write_reg = 5'd12; write_data = 64'd12;
    check("setclr", 5'd0, 5'd0, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0; reg_write = 1'b0;
    check("set_wins", 5'd0, 5'd12, 64'd0, 64'd12, c_sb);
    reg_write = 1'b1; write_reg = 5'd12; write_data = 64'd99;
    check("clr12_byp", 5'd12, 5'd0, 64'd99, 64'd0, 1'b0);
    @(negedge clk);
    reg_write = 1'b0;
    check("clr12_done", 5'd12, 5'd12, 64'd99, 64'd99, 1'b0);

    // Reset drops all pending busy bits.
    issue_valid = 1'b1; issue_dest = 5'd13;
    @(negedge clk);
    issue_valid = 1'b0;
    check("busy13", 5'd13, 5'd0, 64'd0, 64'd0, c_sb);
    #10 rst = 1'b1;
    check("busy13_rst", 5'd13, 5'd13, 64'd0, 64'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("busy13_clr", 5'd13, 5'd12, 64'd0, 64'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
